// File: rtl/hazard_ctrl.sv
// Hazard and forwarding controller for a 5-stage MIPS pipeline: keeps a shadow
// copy of E/M/W destination info and derives stalls, bubbles and bypass selects.
module hazard_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10,
  parameter int CNT_W       = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] d_tuse1,
  input  logic [1:0] d_tuse2,
  input  logic [4:0] d_ra1,
  input  logic [4:0] d_ra2,
  input  logic [1:0] d_tnew,
  input  logic [4:0] d_wa,
  input  logic       d_mduclass,
  input  logic [1:0] d_mdu_op,
  output logic       stall,
  output logic       e_bubble,
  output logic [1:0] fwd_d1,
  output logic [1:0] fwd_d2,
  output logic [1:0] fwd_e1,
  output logic [1:0] fwd_e2,
  output logic       fwd_m2,
  output logic       mdu_busy
);

  logic [1:0]       tnew_e_q, tnew_e_d;
  logic [4:0]       wa_e_q, wa_e_d;
  logic [4:0]       ra1_e_q, ra1_e_d;
  logic [4:0]       ra2_e_q, ra2_e_d;
  logic [1:0]       mdu_op_e_q, mdu_op_e_d;
  logic [1:0]       tnew_m_q, tnew_m_d;
  logic [4:0]       wa_m_q, wa_m_d;
  logic [4:0]       ra2_m_q, ra2_m_d;
  logic [4:0]       wa_w_q, wa_w_d;
  logic [CNT_W-1:0] mdu_cnt_q, mdu_cnt_d;

  logic stall_raw;
  logic mdu_stall;

  function automatic logic [1:0] sat_dec(input logic [1:0] v);
    return (v == 2'd0) ? 2'd0 : v - 2'd1;
  endfunction

  function automatic logic data_hazard(
    input logic [4:0] ra, input logic [1:0] tuse,
    input logic [4:0] wa_e, input logic [1:0] tnew_e,
    input logic [4:0] wa_m, input logic [1:0] tnew_m
  );
    return (ra != 5'd0) &&
           (((ra == wa_e) && (tnew_e > tuse)) || ((ra == wa_m) && (tnew_m > tuse)));
  endfunction

  // Only a producer whose result already exists (tnew == 0) may bypass.
  function automatic logic [1:0] fwd_d_sel(
    input logic [4:0] ra,
    input logic [4:0] wa_e, input logic [1:0] tnew_e,
    input logic [4:0] wa_m, input logic [1:0] tnew_m,
    input logic [4:0] wa_w
  );
    if (ra == 5'd0)                         return 2'd0;
    if ((ra == wa_e) && (tnew_e == 2'd0))   return 2'd1;
    if ((ra == wa_m) && (tnew_m == 2'd0))   return 2'd2;
    if (ra == wa_w)                         return 2'd3;
    return 2'd0;
  endfunction

  function automatic logic [1:0] fwd_e_sel(
    input logic [4:0] ra,
    input logic [4:0] wa_m, input logic [1:0] tnew_m,
    input logic [4:0] wa_w
  );
    if (ra == 5'd0)                         return 2'd0;
    if ((ra == wa_m) && (tnew_m == 2'd0))   return 2'd1;
    if (ra == wa_w)                         return 2'd2;
    return 2'd0;
  endfunction

  always_comb begin
    mdu_stall = d_mduclass && ((mdu_op_e_q != 2'd0) || (mdu_cnt_q != '0));
    stall_raw = data_hazard(d_ra1, d_tuse1, wa_e_q, tnew_e_q, wa_m_q, tnew_m_q) ||
                data_hazard(d_ra2, d_tuse2, wa_e_q, tnew_e_q, wa_m_q, tnew_m_q) ||
                mdu_stall;

    stall    = stall_raw && !reset;
    e_bubble = stall;
    fwd_d1   = reset ? 2'd0 : fwd_d_sel(d_ra1, wa_e_q, tnew_e_q, wa_m_q, tnew_m_q, wa_w_q);
    fwd_d2   = reset ? 2'd0 : fwd_d_sel(d_ra2, wa_e_q, tnew_e_q, wa_m_q, tnew_m_q, wa_w_q);
    fwd_e1   = reset ? 2'd0 : fwd_e_sel(ra1_e_q, wa_m_q, tnew_m_q, wa_w_q);
    fwd_e2   = reset ? 2'd0 : fwd_e_sel(ra2_e_q, wa_m_q, tnew_m_q, wa_w_q);
    fwd_m2   = !reset && (ra2_m_q != 5'd0) && (ra2_m_q == wa_w_q);
    mdu_busy = !reset && (mdu_cnt_q != '0);
  end

  always_comb begin
    tnew_e_d   = 2'd0;
    wa_e_d     = 5'd0;
    ra1_e_d    = 5'd0;
    ra2_e_d    = 5'd0;
    mdu_op_e_d = 2'd0;
    if (!stall) begin
      tnew_e_d   = sat_dec(d_tnew);
      wa_e_d     = d_wa;
      ra1_e_d    = d_ra1;
      ra2_e_d    = d_ra2;
      // The reserved encoding 11 starts nothing.
      mdu_op_e_d = (d_mdu_op == 2'b11) ? 2'b00 : d_mdu_op;
    end

    tnew_m_d = sat_dec(tnew_e_q);
    wa_m_d   = wa_e_q;
    ra2_m_d  = ra2_e_q;
    wa_w_d   = wa_m_q;

    case (mdu_op_e_q)
      2'b01:   mdu_cnt_d = CNT_W'(MULT_CYCLES);
      2'b10:   mdu_cnt_d = CNT_W'(DIV_CYCLES);
      default: mdu_cnt_d = (mdu_cnt_q != '0) ? mdu_cnt_q - CNT_W'(1) : mdu_cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tnew_e_q   <= 2'd0;
      wa_e_q     <= 5'd0;
      ra1_e_q    <= 5'd0;
      ra2_e_q    <= 5'd0;
      mdu_op_e_q <= 2'd0;
      tnew_m_q   <= 2'd0;
      wa_m_q     <= 5'd0;
      ra2_m_q    <= 5'd0;
      wa_w_q     <= 5'd0;
      mdu_cnt_q  <= '0;
    end else begin
      tnew_e_q   <= tnew_e_d;
      wa_e_q     <= wa_e_d;
      ra1_e_q    <= ra1_e_d;
      ra2_e_q    <= ra2_e_d;
      mdu_op_e_q <= mdu_op_e_d;
      tnew_m_q   <= tnew_m_d;
      wa_m_q     <= wa_m_d;
      ra2_m_q    <= ra2_m_d;
      wa_w_q     <= wa_w_d;
      mdu_cnt_q  <= mdu_cnt_d;
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: directed pipeline scenarios plus random instruction
// streams, each cycle checked against a behavioural pipeline model.
module tb_hazard_ctrl;

  localparam int MULT = 5;
  localparam int DIV  = 10;
  localparam int RUN_LIMIT = 16;

  typedef struct packed {
    logic [1:0] tuse1;
    logic [1:0] tuse2;
    logic [4:0] ra1;
    logic [4:0] ra2;
    logic [1:0] tnew;
    logic [4:0] wa;
    logic       mdu;
    logic [1:0] op;
  } instr_t;

  typedef struct packed {
    logic       stall;
    logic       e_bubble;
    logic [1:0] fwd_d1;
    logic [1:0] fwd_d2;
    logic [1:0] fwd_e1;
    logic [1:0] fwd_e2;
    logic       fwd_m2;
    logic       mdu_busy;
  } out_t;

  logic       clk;
  logic       reset;
  logic [1:0] d_tuse1, d_tuse2, d_tnew, d_mdu_op;
  logic [4:0] d_ra1, d_ra2, d_wa;
  logic       d_mduclass;
  logic       stall, e_bubble, fwd_m2, mdu_busy;
  logic [1:0] fwd_d1, fwd_d2, fwd_e1, fwd_e2;

  logic [11:0] exp_q[$];
  int total = 0;
  int bad   = 0;

  // behavioural model state
  int m_tnew_e, m_wa_e, m_ra1_e, m_ra2_e, m_op_e;
  int m_tnew_m, m_wa_m, m_ra2_m, m_wa_w, m_cnt;

  hazard_ctrl #(.MULT_CYCLES(MULT), .DIV_CYCLES(DIV), .CNT_W(4)) dut (
    .clk(clk), .reset(reset),
    .d_tuse1(d_tuse1), .d_tuse2(d_tuse2), .d_ra1(d_ra1), .d_ra2(d_ra2),
    .d_tnew(d_tnew), .d_wa(d_wa), .d_mduclass(d_mduclass), .d_mdu_op(d_mdu_op),
    .stall(stall), .e_bubble(e_bubble),
    .fwd_d1(fwd_d1), .fwd_d2(fwd_d2), .fwd_e1(fwd_e1), .fwd_e2(fwd_e2),
    .fwd_m2(fwd_m2), .mdu_busy(mdu_busy)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // instruction builders
  function automatic instr_t i_nop();
    instr_t i = '0;
    return i;
  endfunction
  function automatic instr_t i_lw(input logic [4:0] rt, input logic [4:0] base);
    instr_t i = '0;
    i.ra1 = base; i.tuse1 = 2'd1; i.tnew = 2'd3; i.wa = rt;
    return i;
  endfunction
  function automatic instr_t i_sw(input logic [4:0] rt, input logic [4:0] base);
    instr_t i = '0;
    i.ra1 = base; i.tuse1 = 2'd1; i.ra2 = rt; i.tuse2 = 2'd2;
    return i;
  endfunction
  function automatic instr_t i_addu(input logic [4:0] rd, input logic [4:0] rs, input logic [4:0] rt);
    instr_t i = '0;
    i.ra1 = rs; i.tuse1 = 2'd1; i.ra2 = rt; i.tuse2 = 2'd1; i.tnew = 2'd2; i.wa = rd;
    return i;
  endfunction
  function automatic instr_t i_beq(input logic [4:0] rs, input logic [4:0] rt);
    instr_t i = '0;
    i.ra1 = rs; i.ra2 = rt;
    return i;
  endfunction
  function automatic instr_t i_jal();
    instr_t i = '0;
    i.tnew = 2'd1; i.wa = 5'd31;
    return i;
  endfunction
  function automatic instr_t i_jr(input logic [4:0] rs);
    instr_t i = '0;
    i.ra1 = rs;
    return i;
  endfunction
  function automatic instr_t i_md(input logic [4:0] rs, input logic [4:0] rt, input logic [1:0] op);
    instr_t i = '0;
    i.ra1 = rs; i.tuse1 = 2'd1; i.ra2 = rt; i.tuse2 = 2'd1; i.mdu = 1'b1; i.op = op;
    return i;
  endfunction
  function automatic instr_t i_mflo(input logic [4:0] rd);
    instr_t i = '0;
    i.mdu = 1'b1; i.tnew = 2'd2; i.wa = rd;
    return i;
  endfunction

  // model
  function automatic logic m_hz(input int ra, input int tuse);
    if (ra == 0) return 1'b0;
    if (ra == m_wa_e && m_tnew_e > tuse) return 1'b1;
    if (ra == m_wa_m && m_tnew_m > tuse) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [1:0] m_fd(input int ra);
    if (ra == 0) return 2'd0;
    if (ra == m_wa_e) return (m_tnew_e == 0) ? 2'd1 :
                           ((ra == m_wa_m && m_tnew_m == 0) ? 2'd2 : (ra == m_wa_w ? 2'd3 : 2'd0));
    if (ra == m_wa_m) return (m_tnew_m == 0) ? 2'd2 : (ra == m_wa_w ? 2'd3 : 2'd0);
    if (ra == m_wa_w) return 2'd3;
    return 2'd0;
  endfunction

  function automatic logic [1:0] m_fe(input int ra);
    if (ra == 0) return 2'd0;
    if (ra == m_wa_m && m_tnew_m == 0) return 2'd1;
    if (ra == m_wa_w) return 2'd2;
    return 2'd0;
  endfunction

  function automatic out_t model_out(input instr_t in);
    out_t o = '0;
    o.stall    = m_hz(int'(in.ra1), int'(in.tuse1)) || m_hz(int'(in.ra2), int'(in.tuse2)) ||
                 (in.mdu && (m_op_e != 0 || m_cnt != 0));
    o.e_bubble = o.stall;
    o.fwd_d1   = m_fd(int'(in.ra1));
    o.fwd_d2   = m_fd(int'(in.ra2));
    o.fwd_e1   = m_fe(m_ra1_e);
    o.fwd_e2   = m_fe(m_ra2_e);
    o.fwd_m2   = (m_ra2_m != 0) && (m_ra2_m == m_wa_w);
    o.mdu_busy = (m_cnt != 0);
    return o;
  endfunction

  task automatic model_clear();
    m_tnew_e = 0; m_wa_e = 0; m_ra1_e = 0; m_ra2_e = 0; m_op_e = 0;
    m_tnew_m = 0; m_wa_m = 0; m_ra2_m = 0; m_wa_w = 0; m_cnt = 0;
  endtask

  task automatic model_adv(input instr_t in, input logic st);
    int n_cnt;
    n_cnt = (m_op_e == 1) ? MULT : (m_op_e == 2) ? DIV : (m_cnt > 0 ? m_cnt - 1 : 0);
    m_wa_w   = m_wa_m;
    m_tnew_m = (m_tnew_e > 0) ? m_tnew_e - 1 : 0;
    m_wa_m   = m_wa_e;
    m_ra2_m  = m_ra2_e;
    m_cnt    = n_cnt;
    if (st) begin
      m_tnew_e = 0; m_wa_e = 0; m_ra1_e = 0; m_ra2_e = 0; m_op_e = 0;
    end else begin
      m_tnew_e = (int'(in.tnew) > 0) ? int'(in.tnew) - 1 : 0;
      m_wa_e   = int'(in.wa);
      m_ra1_e  = int'(in.ra1);
      m_ra2_e  = int'(in.ra2);
      m_op_e   = (in.op == 2'b11) ? 0 : int'(in.op);
    end
  endtask

  // driver: one clock with one D-stage instruction presented
  task automatic tick(input instr_t in, input logic rst, output out_t got, output out_t e);
    d_tuse1 = in.tuse1; d_tuse2 = in.tuse2; d_ra1 = in.ra1; d_ra2 = in.ra2;
    d_tnew = in.tnew; d_wa = in.wa; d_mduclass = in.mdu; d_mdu_op = in.op;
    reset = rst;
    e = rst ? out_t'('0) : model_out(in);
    exp_q.push_back(e);
    @(negedge clk);
    got = {stall, e_bubble, fwd_d1, fwd_d2, fwd_e1, fwd_e2, fwd_m2, mdu_busy};
    check_val("outputs", got, exp_q.pop_front());
    @(posedge clk);
    if (rst) model_clear();
    else model_adv(in, e.stall);
    #1;
  endtask

  // hold an instruction in D until it issues
  task automatic run_instr(input instr_t in, output int cycles, output int stalls,
                           output int busy, output out_t first, output out_t last);
    out_t got, e;
    logic done;
    cycles = 0; stalls = 0; busy = 0; done = 1'b0;
    first = '0; last = '0;
    for (int n = 0; n < RUN_LIMIT && !done; n++) begin
      tick(in, 1'b0, got, e);
      if (cycles == 0) first = got;
      last = got;
      cycles++;
      if (got.stall) stalls++;
      if (got.mdu_busy) busy++;
      if (!e.stall) done = 1'b1;
    end
    check_val("run_bound", {31'd0, done}, 32'd1);
  endtask

  task automatic flush();
    int c, s, b;
    out_t f, l;
    for (int n = 0; n < 4; n++) run_instr(i_nop(), c, s, b, f, l);
  endtask

  initial begin
    int c, s, b;
    out_t f, l, got, e;
    instr_t r;

    reset = 1'b1;
    d_tuse1 = '0; d_tuse2 = '0; d_ra1 = '0; d_ra2 = '0;
    d_tnew = '0; d_wa = '0; d_mduclass = 1'b0; d_mdu_op = '0;
    model_clear();
    @(posedge clk);
    #1;

    tick(i_addu(5'd1, 5'd1, 5'd2), 1'b1, got, e);
    tick(i_lw(5'd3, 5'd3), 1'b1, got, e);
    check_val("reset_outputs", 32'(got), 32'd0);

    // load-use
    run_instr(i_lw(5'd1, 5'd0), c, s, b, f, l);
    run_instr(i_addu(5'd2, 5'd1, 5'd3), c, s, b, f, l);
    check_val("lu_stalls", s, 1);
    check_val("lu_first_stall", 32'(f.stall), 1);
    check_val("lu_fwd_d1", 32'(l.fwd_d1), 0);
    run_instr(i_nop(), c, s, b, f, l);
    check_val("lu_fwd_e1", 32'(f.fwd_e1), 2);
    flush();

    // ALU result to branch
    run_instr(i_addu(5'd1, 5'd2, 5'd3), c, s, b, f, l);
    run_instr(i_beq(5'd1, 5'd0), c, s, b, f, l);
    check_val("br_stalls", s, 1);
    check_val("br_fwd_d1", 32'(l.fwd_d1), 2);
    flush();

    // jal then jr $31
    run_instr(i_jal(), c, s, b, f, l);
    run_instr(i_jr(5'd31), c, s, b, f, l);
    check_val("jr_stalls", s, 0);
    check_val("jr_fwd_d1", 32'(f.fwd_d1), 1);
    flush();

    // mult / mflo
    run_instr(i_md(5'd4, 5'd5, 2'b01), c, s, b, f, l);
    run_instr(i_mflo(5'd6), c, s, b, f, l);
    check_val("mult_stalls", s, 6);
    check_val("mult_busy", b, 5);
    check_val("mult_issue_cycle", c, 7);
    flush();

    // div / mflo
    run_instr(i_md(5'd4, 5'd5, 2'b10), c, s, b, f, l);
    run_instr(i_mflo(5'd6), c, s, b, f, l);
    check_val("div_stalls", s, 11);
    check_val("div_busy", b, 10);
    flush();

    // $0 never hazards
    run_instr(i_lw(5'd0, 5'd0), c, s, b, f, l);
    run_instr(i_addu(5'd2, 5'd0, 5'd0), c, s, b, f, l);
    check_val("r0_stalls", s, 0);
    check_val("r0_fwd", {28'd0, f.fwd_d1, f.fwd_d2}, 0);
    flush();

    // store data bypass from W
    run_instr(i_addu(5'd7, 5'd1, 5'd2), c, s, b, f, l);
    run_instr(i_sw(5'd7, 5'd0), c, s, b, f, l);
    run_instr(i_nop(), c, s, b, f, l);
    check_val("sw_fwd_e2", 32'(f.fwd_e2), 1);
    run_instr(i_nop(), c, s, b, f, l);
    check_val("sw_fwd_m2", 32'(f.fwd_m2), 1);
    flush();

    // reset in the middle of a divide
    run_instr(i_md(5'd4, 5'd5, 2'b10), c, s, b, f, l);
    tick(i_mflo(5'd6), 1'b0, got, e);
    tick(i_mflo(5'd6), 1'b0, got, e);
    check_val("rst_div_busy_before", 32'(got.mdu_busy), 1);
    tick(i_mflo(5'd6), 1'b1, got, e);
    tick(i_mflo(5'd6), 1'b0, got, e);
    check_val("rst_div_busy", 32'(got.mdu_busy), 0);
    check_val("rst_div_stall", 32'(got.stall), 0);
    check_val("rst_div_fwd", {22'd0, got.fwd_d1, got.fwd_d2, got.fwd_e1, got.fwd_e2, got.fwd_m2}, 0);
    flush();

    // random instruction stream over a small register set
    for (int n = 0; n < 300; n++) begin
      case ($urandom_range(0, 9))
        0: r = i_lw(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)));
        1: r = i_sw(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)));
        2, 3: r = i_addu(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)));
        4: r = i_beq(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)));
        5: r = i_jr(5'($urandom_range(0, 3)));
        6: r = i_md(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 2'($urandom_range(0, 3)));
        7: r = i_mflo(5'($urandom_range(0, 3)));
        8: r = i_jal();
        default: r = i_nop();
      endcase
      run_instr(r, c, s, b, f, l);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
